bin_a_bcd: RTL

BIN_A_BCD -- requirements
Module: bin_a_bcd

---
 rtl/bin_a_bcd.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bin_a_bcd.sv
// Sequential double-dabble converter from a WIDTH-bit unsigned product to two BCD digits.
// Optional 7-segment outputs (active-low, common anode) are enabled by defining BIN_A_BCD_SEG7_EN.
module bin_a_bcd #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [WIDTH-1:0] pp,
  output logic [3:0]       dec,
  output logic [3:0]       uni,
  output logic             busy,
  output logic             done
`ifdef BIN_A_BCD_SEG7_EN
  ,
  output logic [6:0]       seg_dec,
  output logic [6:0]       seg_uni
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_t;
  logic [3:0]         r_u;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_cnt;
  logic [3:0]         r_dec;
  logic [3:0]         r_uni;

  logic [3:0]         w_tAdj;
  logic [3:0]         w_uAdj;
  logic [WIDTH+7:0]   w_shifted;
  logic [2:0]         w_cntDec;
  logic               w_lastShift;

  // Each digit that would overflow past 9 after doubling is pre-biased by 3.
  assign w_tAdj      = (r_t >= 4'd5) ? (r_t + 4'd3) : r_t;
  assign w_uAdj      = (r_u >= 4'd5) ? (r_u + 4'd3) : r_u;
  assign w_shifted   = {r_t[2:0], r_u, r_b, 1'b0};
  assign w_cntDec    = r_cnt - 3'd1;
  assign w_lastShift = (w_cntDec == 3'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (init) begin
          w_next = ADD;
        end
      end
      ADD: begin
        busy   = 1'b1;
        w_next = SHIFT;
      end
      SHIFT: begin
        busy   = 1'b1;
        w_next = w_lastShift ? DONE : ADD;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Working register and result digits; results only move on the final shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_t   <= 4'd0;
      r_u   <= 4'd0;
      r_b   <= '0;
      r_cnt <= 3'd0;
      r_dec <= 4'd0;
      r_uni <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (init) begin
            r_t   <= 4'd0;
            r_u   <= 4'd0;
            r_b   <= pp;
            r_cnt <= 3'(WIDTH);
          end
        end
        ADD: begin
          r_t <= w_tAdj;
          r_u <= w_uAdj;
        end
        SHIFT: begin
          r_t   <= w_shifted[WIDTH+7:WIDTH+4];
          r_u   <= w_shifted[WIDTH+3:WIDTH];
          r_b   <= w_shifted[WIDTH-1:0];
          r_cnt <= w_cntDec;
          if (w_lastShift) begin
            r_dec <= w_shifted[WIDTH+7:WIDTH+4];
            r_uni <= w_shifted[WIDTH+3:WIDTH];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dec = r_dec;
  assign uni = r_uni;

`ifdef BIN_A_BCD_SEG7_EN
  // Segment order is g..a from bit 6 down to bit 0; a low bit lights the segment.
  function automatic logic [6:0] segDecode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  assign seg_dec = segDecode(r_dec);
  assign seg_uni = segDecode(r_uni);
`endif

endmodule
